// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Defining DCACHE_STATS_EN adds the hit_cnt_o / miss_cnt_o access counters.
module dcache_ctrl #(
   parameter  int unsigned LINES = 16,
   localparam int unsigned IDX_W = $clog2(LINES)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   input  logic         cpu_MemRead_i,
   input  logic         cpu_MemWrite_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]  hit_cnt_o,
   output logic [31:0]  miss_cnt_o
`endif
);

   localparam int unsigned TAG_W = 27 - IDX_W;

   typedef enum logic [1:0] {IDLE, WB, ALLOC, REFILL} state_e;

   state_e             state_q;
   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [255:0]       data_q [LINES];

   logic [2:0]         word;
   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic [7:0]         bit_off;
   logic               req;
   logic               hit;
   logic               unused_addr;

   assign word        = cpu_addr_i[4:2];
   assign idx         = cpu_addr_i[4+IDX_W:5];
   assign tag         = cpu_addr_i[31:5+IDX_W];
   assign bit_off     = {word, 5'b0};
   assign req         = cpu_MemRead_i | cpu_MemWrite_i;
   assign hit         = valid_q[idx] && (tag_q[idx] == tag);
   assign unused_addr = ^cpu_addr_i[1:0];

   // Address is held stable by the stalled pipeline, so the memory-side
   // address/data can be decoded directly from it for the whole request.
   always_comb begin
      cpu_stall_o = (state_q != IDLE) || (req && !hit);
      cpu_data_o  = '0;
      if (state_q == IDLE && cpu_MemRead_i && !cpu_MemWrite_i && hit)
         cpu_data_o = data_q[idx][bit_off +: 32];
      mem_addr_o = {tag, idx, 5'b0};
      if (state_q == WB)
         mem_addr_o = {tag_q[idx], idx, 5'b0};
      mem_data_o = data_q[idx];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  if (hit) begin
                     if (cpu_MemWrite_i) begin
                        data_q[idx][bit_off +: 32] <= cpu_data_i;
                        dirty_q[idx]               <= 1'b1;
                     end
                  end else if (valid_q[idx] && dirty_q[idx]) begin
                     state_q      <= WB;
                     mem_enable_o <= 1'b1;
                     mem_write_o  <= 1'b1;
                  end else begin
                     state_q      <= ALLOC;
                     mem_enable_o <= 1'b1;
                     mem_write_o  <= 1'b0;
                  end
               end
            end
            WB: begin
               if (mem_ack_i) begin
                  state_q     <= ALLOC;
                  mem_write_o <= 1'b0;
               end
            end
            ALLOC: begin
               if (mem_ack_i) begin
                  state_q      <= REFILL;
                  mem_enable_o <= 1'b0;
                  data_q[idx]  <= mem_data_i;
                  tag_q[idx]   <= tag;
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
               end
            end
            REFILL:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   // The lookup right after REFILL is the completion of a counted miss.
   logic after_refill_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_o      <= '0;
         miss_cnt_o     <= '0;
         after_refill_q <= 1'b0;
      end else begin
         after_refill_q <= (state_q == REFILL);
         if (state_q == IDLE && req) begin
            if (!hit)
               miss_cnt_o <= miss_cnt_o + 32'd1;
            else if (!after_refill_q)
               hit_cnt_o <= hit_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected loads and memory requests are queued
// at stimulus time and compared as the cache completes them.
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic         cpu_MemRead_i;
   logic         cpu_MemWrite_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt_o;
   logic [31:0]  miss_cnt_o;
`endif

   dcache_ctrl #(.LINES(16)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .cpu_addr_i     (cpu_addr_i),
      .cpu_data_i     (cpu_data_i),
      .cpu_MemRead_i  (cpu_MemRead_i),
      .cpu_MemWrite_i (cpu_MemWrite_i),
      .cpu_data_o     (cpu_data_o),
      .cpu_stall_o    (cpu_stall_o),
      .mem_data_i     (mem_data_i),
      .mem_ack_i      (mem_ack_i),
      .mem_enable_o   (mem_enable_o),
      .mem_write_o    (mem_write_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt_o      (hit_cnt_o),
      .miss_cnt_o     (miss_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] word1;
   } req_t;

   req_t        exp_req_q[$];
   logic [31:0] exp_load_q[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mem_line(input logic [31:0] a);
      logic [255:0] l;
      for (int unsigned w = 0; w < 8; w++)
         l[32*w +: 32] = a + 32'(4 * w);
      if (a == 32'h40)
         l[31:0] = 32'hDEADBEEF;
      return l;
   endfunction

   task automatic push_req(input logic [31:0] addr, input logic wr, input logic [31:0] word1);
      req_t r;
      r.addr  = addr;
      r.wr    = wr;
      r.word1 = word1;
      exp_req_q.push_back(r);
   endtask

   // Drives one access and plays the memory side; ack comes on the dly-th cycle of each request.
   task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input int unsigned dly,
                         input int unsigned exp_stall);
      int unsigned stalls = 0;
      int unsigned k = 0;
      bit          need_new = 1'b1;
      bit          done = 1'b0;
      req_t        cur;
      cur.addr = '0; cur.wr = 1'b0; cur.word1 = '0;
      if (!wr) exp_load_q.push_back(exp_data);
      cpu_addr_i     = addr;
      cpu_data_i     = wdata;
      cpu_MemRead_i  = !wr;
      cpu_MemWrite_i = wr;
      for (int unsigned cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (cpu_stall_o) begin
            stalls++;
            if (mem_enable_o) begin
               if (need_new) begin
                  need_new = 1'b0;
                  k = 0;
                  if (exp_req_q.size() == 0) begin
                     check("unexpected_req", mem_addr_o, 32'hFFFF_FFFF);
                  end else begin
                     cur = exp_req_q.pop_front();
                     check("req_addr", mem_addr_o, cur.addr);
                     check("req_write", 32'(mem_write_o), 32'(cur.wr));
                     if (cur.wr) check("wb_word1", mem_data_o[63:32], cur.word1);
                  end
               end else begin
                  check("hold_addr", mem_addr_o, cur.addr);
                  check("hold_write", 32'(mem_write_o), 32'(cur.wr));
               end
               k++;
               if (k == dly) begin
                  mem_data_i = mem_line(cur.addr);
                  mem_ack_i  = 1'b1;
                  need_new   = 1'b1;
               end
            end
         end else begin
            if (!wr) begin
               if (exp_load_q.size() == 0) check("load_q_empty", cpu_data_o, 32'hFFFF_FFFF);
               else check("load_data", cpu_data_o, exp_load_q.pop_front());
            end
            check("stall_cycles", stalls, exp_stall);
            done = 1'b1;
         end
      end
      if (!done) check("timeout", 32'd0, 32'd1);
      @(posedge clk_i);
      #1;
      cpu_MemRead_i  = 1'b0;
      cpu_MemWrite_i = 1'b0;
   endtask

   initial begin
      bit found;
      rst_i          = 1'b1;
      cpu_addr_i     = '0;
      cpu_data_i     = '0;
      cpu_MemRead_i  = 1'b0;
      cpu_MemWrite_i = 1'b0;
      mem_data_i     = '0;
      mem_ack_i      = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;

      @(negedge clk_i);
      check("rst_enable", 32'(mem_enable_o), 32'd0);
      check("rst_write", 32'(mem_write_o), 32'd0);
      check("rst_stall", 32'(cpu_stall_o), 32'd0);
      check("rst_data", cpu_data_o, 32'd0);
      @(posedge clk_i);
      #1;

      push_req(32'h40, 1'b0, 32'h0);
      access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 3, 5);
      access(1'b1, 32'h44, 32'h12345678, 32'h0, 1, 0);
      access(1'b0, 32'h44, 32'h0, 32'h12345678, 1, 0);

      push_req(32'h40, 1'b1, 32'h12345678);
      push_req(32'h240, 1'b0, 32'h0);
      access(1'b0, 32'h240, 32'h0, 32'h240, 10, 22);
      check("req_q_drained", 32'(exp_req_q.size()), 32'd0);

`ifdef DCACHE_STATS_EN
      check("miss_cnt", miss_cnt_o, 32'd2);
      check("hit_cnt", hit_cnt_o, 32'd2);
`endif

      mem_ack_i = 1'b1;
      @(posedge clk_i);
      #1 mem_ack_i = 1'b0;
      @(negedge clk_i);
      check("spurious_enable", 32'(mem_enable_o), 32'd0);
      check("spurious_stall", 32'(cpu_stall_o), 32'd0);
      @(posedge clk_i);
      #1;
      access(1'b0, 32'h244, 32'h0, 32'h244, 1, 0);

      cpu_addr_i    = 32'h40;
      cpu_MemRead_i = 1'b1;
      found = 1'b0;
      for (int unsigned c = 0; c < 20 && !found; c++) begin
         @(negedge clk_i);
         if (mem_enable_o) found = 1'b1;
      end
      check("alloc_seen", 32'(found), 32'd1);
      check("alloc_addr", mem_addr_o, 32'h40);
      check("alloc_write", 32'(mem_write_o), 32'd0);
      rst_i         = 1'b1;
      cpu_MemRead_i = 1'b0;
      @(negedge clk_i);
      check("midrst_enable", 32'(mem_enable_o), 32'd0);
      check("midrst_stall", 32'(cpu_stall_o), 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      push_req(32'h40, 1'b0, 32'h0);
      access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2, 4);
      check("load_q_drained", 32'(exp_load_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage.
- Consumes the EX/MEM register outputs (MemRead, MemWrite, ALU result as address, store data).
- Returns load data towards MEM/WB.
- Drives cpu_stall_o, which feeds the Mem_stall input of the upstream pipeline registers. It also drives a 256-bit line interface to off-chip data memory.

Parameters:
- LINES, 16, number of cache lines; must be a power of two, 2..256.
- IDX_W, $clog2(LINES), index width; derived, not overridden.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- cpu_addr_i  input  32  byte address from EX/MEM ALU result
- cpu_data_i  input  32  store data from EX/MEM
- cpu_MemRead_i  input  1  load request
- cpu_MemWrite_i  input  1  store request
- cpu_data_o  output  32  load data
- cpu_stall_o  output  1  stall to pipeline (Mem_stall)
- mem_data_i  input  256  refill line from memory
- mem_ack_i  input  1  one-cycle memory completion pulse
- mem_enable_o  output  1  memory request
- mem_write_o  output  1  1 = write-back, 0 = refill read
- mem_addr_o  output  32  line address, bits [4:0] = 0
- mem_data_o  output  256  victim line for write-back

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Address split:
  - word = addr[4:2]; addr[1:0] ignored.
  - index = addr[4+IDX_W:5]; tag = addr[31:5+IDX_W].
  - Word w occupies line bits [32w+31:32w].
- Storage per line: valid, dirty, tag, 256-bit data.
- Reset: all valid = 0, all dirty = 0, state = IDLE, mem_enable_o = 0, mem_write_o = 0. cpu_stall_o and cpu_data_o follow the IDLE equations.
- Request: req = cpu_MemRead_i | cpu_MemWrite_i. If both are asserted, treat as a store.
- Hit: valid[index] & (tag[index] == tag).
- IDLE:
  - cpu_stall_o = req & ~hit (combinational).
  - Read hit: cpu_data_o = addressed word in the same cycle, zero latency. Otherwise cpu_data_o = 0.
  - Write hit: at posedge, write the word and set dirty.
  - Miss with victim valid & dirty: go to WB. Otherwise go to ALLOC.
- WB:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
  - Hold until mem_ack_i, then go to ALLOC.
- ALLOC:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}.
  - Hold until mem_ack_i. On ack, capture mem_data_i into the line; set valid = 1, dirty = 0, tag = tag. Go to REFILL.
- REFILL: one cycle, no memory request, then go to IDLE. The held request now hits and completes (a store sets dirty then).
- cpu_stall_o = 1 in WB, ALLOC and REFILL.
- Memory outputs: mem_enable_o and mem_write_o are registered with the state. mem_addr_o and mem_data_o are stable for the whole request.
- Address stability: the address is sampled continuously. The pipeline guarantees inputs are stable while stalled.
- Clean-miss latency: the stall spans 1 (IDLE) + N (ALLOC cycles up to and including the ack) + 1 (REFILL) cycles. A dirty miss adds the WB cycles.
- mem_ack_i outside WB/ALLOC: ignored.
- No request (req = 0): no state change, cpu_stall_o = 0.
- Reset mid-miss: return to IDLE next cycle with mem_enable_o = 0. The in-flight response is discarded and all lines are invalidated.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both cleared by rst_i. Both wrap at 2^32.
  - hit_cnt_o increments once per completed access that hit on first lookup.
  - miss_cnt_o increments once per IDLE→WB/ALLOC transition.
  - A request that misses and then completes after REFILL counts as a miss only.
- Undefined: no counters and no such ports.

Test Plan:
- Reset, then load 0x0000_0040: stall 1 + N + 1 cycles with mem_addr_o = 0x40 and mem_write_o = 0. Memory returns a line with word0 = 0xDEADBEEF; after REFILL, cpu_data_o = 0xDEADBEEF and stall drops.
- Store 0x12345678 to 0x44 (same line, valid): no stall. A following load of 0x44 returns 0x12345678 with zero latency.
- Load 0x0000_0240 (LINES = 16, same index as 0x40, different tag, dirty): WB request at 0x40 with mem_data_o word1 = 0x12345678, then ALLOC at 0x240.
- Memory ack delayed 10 cycles: cpu_stall_o held high throughout and mem_enable_o is stable. A spurious mem_ack_i in IDLE has no effect.
- rst_i asserted during ALLOC: next cycle mem_enable_o = 0 and stall = 0. A load of 0x40 then misses again.
- With DCACHE_STATS_EN, run the above sequence: miss_cnt_o = 2 and hit_cnt_o = 2 before the reset.
